// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared defaults, state encoding and arbitration modes for npc_arb
package npc_pkg;

    localparam int NCH_DEF = 4;
    localparam int AW_DEF  = 32;
    localparam int LW_DEF  = 32;
    localparam int DW_DEF  = 64;

    localparam int ARB_RR  = 0;
    localparam int ARB_FIX = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_t;

endpackage

// File: rtl/npc_rr_pick.sv
// rtl/npc_rr_pick.sv - combinational rotating-priority picker over an NCH-bit request vector
module npc_rr_pick
    import npc_pkg::*;
#(
    parameter  int NCH = NCH_DEF,
    localparam int PW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    input  logic           mode,
    output logic [PW-1:0]  win,
    output logic           valid
);

    // Fixed priority is the rotating search anchored at channel 0.
    always_comb begin
        int base;
        int idx;
        base  = mode ? 0 : int'(ptr);
        idx   = 0;
        win   = '0;
        valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = base + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/npc_arb.sv
// rtl/npc_arb.sv - N-channel arbiter sharing one npc memory port between npc cores
module npc_arb
    import npc_pkg::*;
#(
    parameter  int NCH      = NCH_DEF,
    parameter  int AW       = AW_DEF,
    parameter  int LW       = LW_DEF,
    parameter  int DW       = DW_DEF,
    parameter  int ARB_MODE = ARB_RR,
    localparam int PW       = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_req,
    output logic [NCH-1:0]    ch_gnt,
    input  logic [NCH-1:0]    ch_rwn,
    input  logic [NCH*AW-1:0] ch_adr,
    input  logic [NCH*LW-1:0] ch_len,
    input  logic [NCH*DW-1:0] ch_wdt,
    output logic [DW-1:0]     ch_rdt,
    output logic [NCH-1:0]    ch_ack,
    output logic              npc_req,
    input  logic              npc_gnt,
    output logic              npc_rwn,
    output logic [AW-1:0]     npc_adr,
    output logic [LW-1:0]     npc_len,
    output logic [DW-1:0]     npc_wdt,
    input  logic [DW-1:0]     npc_rdt,
    input  logic              npc_ack,
    output logic              arb_bsy,
    output logic [PW-1:0]     arb_sel
);

    arb_state_t    state, state_nxt;
    logic [PW-1:0] sel, sel_nxt;
    logic [PW-1:0] rr_ptr, rr_ptr_nxt;
    logic [LW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] pick_win;
    logic          pick_valid;
    logic [PW-1:0] sel_inc;
    logic [LW-1:0] sel_len;

    npc_rr_pick #(.NCH(NCH)) u_pick (
        .req   (ch_req),
        .ptr   (rr_ptr),
        .mode  (ARB_MODE == ARB_FIX),
        .win   (pick_win),
        .valid (pick_valid)
    );

    assign sel_len = ch_len[sel*LW +: LW];
    assign sel_inc = (32'(sel) == NCH - 1) ? '0 : sel + 1'b1;
    assign ch_rdt  = npc_rdt;
    assign arb_bsy = (state != ST_IDLE);
    assign arb_sel = sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            sel    <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            rr_ptr <= rr_ptr_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        rr_ptr_nxt = rr_ptr;
        cnt_nxt    = cnt;
        npc_req    = 1'b0;
        npc_rwn    = 1'b0;
        npc_adr    = '0;
        npc_len    = '0;
        npc_wdt    = '0;
        ch_gnt     = '0;
        ch_ack     = '0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_nxt   = pick_win;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                npc_req = 1'b1;
                npc_rwn = ch_rwn[sel];
                npc_adr = ch_adr[sel*AW +: AW];
                npc_len = sel_len;
                // A grant landing in the same cycle as a dropped request still wins,
                // keeping this block in step with the downstream port.
                if (npc_gnt) begin
                    ch_gnt[sel] = 1'b1;
                    cnt_nxt     = sel_len;
                    state_nxt   = (sel_len == '0) ? ST_IDLE : ST_XFER;
                end else if (!ch_req[sel]) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_XFER: begin
                npc_wdt     = ch_wdt[sel*DW +: DW];
                ch_ack[sel] = npc_ack;
                if (npc_ack) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == LW'(1)) begin
                        state_nxt  = ST_IDLE;
                        rr_ptr_nxt = sel_inc;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
